// File: rtl/regfile_zeroize_if.sv
// Bus bundle for regfile_zeroize: read/write ports plus the zeroization handshake.
// The master drives addresses, write data and requests; the slave returns data and status.
interface regfile_zeroize_if #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NREAD = 3
) ();
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NREAD*AW-1:0]    read_reg;
  logic [NREAD*WIDTH-1:0] read_data;
  logic [AW-1:0]          write_reg;
  logic [WIDTH-1:0]       write_data;
  logic                   write_enable;
  logic                   zeroize_req;
  logic                   zeroize_busy;
  logic                   zeroize_done;
  logic                   write_reject;

  modport master (
    output read_reg, write_reg, write_data, write_enable, zeroize_req,
    input  read_data, zeroize_busy, zeroize_done, write_reject
  );

  modport slave (
    input  read_reg, write_reg, write_data, write_enable, zeroize_req,
    output read_data, zeroize_busy, zeroize_done, write_reject
  );
endinterface

// File: rtl/regfile_zeroize.sv
// Multi-port register file with a hardwired zero register and a one-entry-per-cycle wipe engine.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_zeroize #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NREAD = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  regfile_zeroize_if.slave rf
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ZeroIdx = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic [WIDTH-1:0] regs_q [DEPTH];

  logic idle;
  logic wr_ok;

  assign idle  = (state_q == StIdle);
  assign wr_ok = rf.write_enable && idle && (rf.write_reg != ZeroIdx);

  assign rf.zeroize_busy = (state_q == StSweep);
  assign rf.zeroize_done = (state_q == StDone);
  assign rf.write_reject = rf.write_enable && !idle;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wr_ok) begin
            regs_q[rf.write_reg] <= rf.write_data;
          end
          if (rf.zeroize_req) begin
            state_q <= StSweep;
            cnt_q   <= '0;
          end
        end
        StSweep: begin
          regs_q[cnt_q] <= '0;
          // cnt wraps back to 0 on the final entry
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == ZeroIdx) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Reads are masked to zero whenever the engine is active; masking beats forwarding.
  always_comb begin
    rf.read_data = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (idle && (rf.read_reg[k*AW +: AW] != ZeroIdx)) begin
        rf.read_data[k*WIDTH +: WIDTH] = regs_q[rf.read_reg[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (rf.read_reg[k*AW +: AW] == rf.write_reg)) begin
          rf.read_data[k*WIDTH +: WIDTH] = rf.write_data;
        end
`else
`endif
      end
    end
  end
endmodule

// File: tb/tb_regfile_zeroize.sv
// Scoreboard bench for regfile_zeroize: expectations are queued from a reference model
// when stimulus is driven and compared against the DUT when the outputs are sampled.
module tb_regfile_zeroize;
  localparam int unsigned WIDTH = 128;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned NREAD = 3;

  typedef struct {
    string          tag;
    logic [383:0]   val;
  } sb_item_t;

  logic clk;
  logic rst_n;

  regfile_zeroize_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD)) rf ();

  regfile_zeroize #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rf     (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  sb_item_t     sb_q[$];
  logic [127:0] mdl [32];

  task automatic check_val(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [383:0] val);
    sb_item_t it;
    it.tag = tag;
    it.val = val;
    sb_q.push_back(it);
  endtask

  task automatic pop_chk(input logic [383:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 384'(sb_q.size()), 384'd1);
    end else begin
      it = sb_q.pop_front();
      check_val(it.tag, obs, it.val);
    end
  endtask

  function automatic logic [383:0] flags();
    return 384'({rf.zeroize_busy, rf.zeroize_done, rf.write_reject});
  endfunction

  function automatic logic [383:0] exp_rd(input int a0, input int a1, input int a2);
    return {mdl[a2], mdl[a1], mdl[a0]};
  endfunction

  task automatic set_rd(input int a0, input int a1, input int a2);
    rf.read_reg = {5'(a2), 5'(a1), 5'(a0)};
  endtask

  task automatic rd_chk(input string tag, input int a0, input int a1, input int a2);
    @(negedge clk);
    set_rd(a0, a1, a2);
    push_exp(tag, exp_rd(a0, a1, a2));
    #1;
    pop_chk(rf.read_data);
  endtask

  task automatic rd_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_chk(tag, i, (i + 7) % 32, 31 - i);
    end
  endtask

  task automatic wr(input int a, input logic [127:0] d);
    @(negedge clk);
    rf.write_enable = 1'b1;
    rf.write_reg    = 5'(a);
    rf.write_data   = d;
    push_exp("wr_flags", 384'(3'b000));
    #1;
    pop_chk(flags());
    @(posedge clk);
    #1;
    rf.write_enable = 1'b0;
    if (a != 31) mdl[a] = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    rst_n           = 1'b0;
    rf.read_reg     = '0;
    rf.write_reg    = '0;
    rf.write_data   = '0;
    rf.write_enable = 1'b0;
    rf.zeroize_req  = 1'b0;
    #2;
    push_exp("rst_flags", 384'(3'b000));
    push_exp("rst_rd", 384'd0);
    pop_chk(flags());
    pop_chk(rf.read_data);
    #10;
    rst_n = 1'b1;

    // Reset contents and the zero register
    rd_all("rst_all");
    @(negedge clk);
    rf.write_enable = 1'b1;
    rf.write_reg    = 5'd31;
    rf.write_data   = 128'd31;
    set_rd(31, 31, 31);
    push_exp("zr_rd", 384'd0);
    push_exp("zr_flags", 384'(3'b000));
    #1;
    pop_chk(rf.read_data);
    pop_chk(flags());
    @(posedge clk);
    #1;
    rf.write_enable = 1'b0;
    rd_chk("zr_after", 31, 31, 31);

    // Basic write/read, two ports on the same register
    wr(5, 128'hABC);
    wr(30, 128'hBEE);
    rd_chk("basic_rd", 5, 30, 5);

    // Same-cycle read of the register being written
    @(negedge clk);
    rf.write_enable = 1'b1;
    rf.write_reg    = 5'd7;
    rf.write_data   = 128'h1234;
    set_rd(7, 5, 30);
`ifdef REGFILE_BYPASS_EN
    push_exp("bypass_same", {128'hBEE, 128'hABC, 128'h1234});
`else
    push_exp("bypass_same", {128'hBEE, 128'hABC, 128'h0});
`endif
    #1;
    pop_chk(rf.read_data);
    @(posedge clk);
    #1;
    rf.write_enable = 1'b0;
    mdl[7] = 128'h1234;
    rd_chk("bypass_next", 7, 5, 30);

    // Fill and wipe
    for (int i = 0; i < 31; i++) wr(i, 128'(i + 1) * 128'h1_0000_0000_0000_0001);
    rd_all("fill_all");
    @(negedge clk);
    rf.zeroize_req = 1'b1;
    set_rd(0, 5, 30);
    push_exp("pre_zero_rd", exp_rd(0, 5, 30));
    #1;
    pop_chk(rf.read_data);
    for (int c = 0; c < 32; c++) push_exp("sweep_flags", (c == 10) ? 384'(3'b101) : 384'(3'b100));
    push_exp("done_flags", 384'(3'b010));
    push_exp("idle_flags", 384'(3'b000));
    @(posedge clk);
    #1;
    rf.zeroize_req = 1'b0;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      if (c == 10) begin
        rf.write_enable = 1'b1;
        rf.write_reg    = 5'd3;
        rf.write_data   = 128'hFFFF;
      end
      if (c == 11) rf.write_enable = 1'b0;
      if (c == 20) rf.zeroize_req = 1'b1;
      if (c == 21) rf.zeroize_req = 1'b0;
      #1;
      pop_chk(flags());
      check_val("sweep_rd_mask", rf.read_data, 384'd0);
    end
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    rd_all("post_zero_all");

    // Reset in the middle of a sweep
    wr(20, 128'h20);
    wr(25, 128'h25);
    wr(28, 128'h28);
    @(negedge clk);
    rf.zeroize_req = 1'b1;
    set_rd(20, 25, 28);
    @(posedge clk);
    #1;
    rf.zeroize_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      push_exp("rst_sweep_flags", 384'(3'b100));
      #1;
      pop_chk(flags());
    end
    @(negedge clk);
    rst_n = 1'b0;
    push_exp("midrst_flags", 384'(3'b000));
    push_exp("midrst_rd", 384'd0);
    #1;
    pop_chk(flags());
    pop_chk(rf.read_data);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      push_exp("after_rst_flags", 384'(3'b000));
      #1;
      pop_chk(flags());
    end
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    rd_all("after_rst_all");

    check_val("sb_drained", 384'(sb_q.size()), 384'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
